// File: rtl/pixel_ram_arbiter_if.sv
// Bundled capture, display and frame-buffer signals around the pixel RAM arbiter.
interface pixel_ram_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 17
);
    logic              frameStart;
    logic              wrValid;
    logic [DATA_W-1:0] wrData;
    logic              wrDropped;
    logic              frameDone;
    logic              rdReq;
    logic [ADDR_W-1:0] rdAddr;
    logic              rdAck;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;
    logic [ADDR_W-1:0] ramAddr;
    logic              ramWe;
    logic [DATA_W-1:0] ramWData;
    logic [DATA_W-1:0] ramRData;

    // Arbiter side
    modport slave (
        input  frameStart, wrValid, wrData, rdReq, rdAddr, ramRData,
        output wrDropped, frameDone, rdAck, rdValid, rdData, ramAddr, ramWe, ramWData
    );

    // Camera / display / RAM side
    modport master (
        output frameStart, wrValid, wrData, rdReq, rdAddr, ramRData,
        input  wrDropped, frameDone, rdAck, rdValid, rdData, ramAddr, ramWe, ramWData
    );
endinterface

// File: rtl/pixel_ram_arbiter.sv
// Shares one single-port frame-buffer RAM between camera writes and display reads,
// alternating between the two sides when both want the same cycle.
module pixel_ram_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned FRAME_PIXELS = 76800
) (
    input logic                clk,
    input logic                reset,
    pixel_ram_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    grant_t              r_last_grant;
    logic                r_wr_pend;
    logic [DATA_W-1:0]   r_pend_data;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_rd_s1;
    logic                r_rd_s2;

    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_rd_ack;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_wr_dropped;
    logic                r_frame_done;

    logic                w_grant_wr;
    logic                w_grant_rd;
    logic                w_capture;
    logic                w_drop;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [ADDR_W-1:0]   w_cap_addr;

    // Grant decision, capture/drop qualification and next write address
    always_comb begin
        w_grant_wr  = r_wr_pend && (!bus.rdReq || (r_last_grant == GRANT_READ));
        w_grant_rd  = bus.rdReq && (!r_wr_pend || (r_last_grant == GRANT_WRITE));
        w_addr_next = (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + ADDR_W'(1);
        // frameStart flushes the holding register, so a strobe there always lands
        w_capture   = bus.wrValid && (!r_wr_pend || w_grant_wr || bus.frameStart);
        w_drop      = bus.wrValid && r_wr_pend && !w_grant_wr && !bus.frameStart;
        if (bus.frameStart) begin
            w_cap_addr = '0;
        end else if (w_grant_wr) begin
            w_cap_addr = w_addr_next;
        end else begin
            w_cap_addr = r_wr_addr;
        end
    end

    // RAM port, grant history and handshake pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GRANT_READ;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_rd_ack     <= 1'b0;
            r_wr_dropped <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_ack     <= w_grant_rd;
            r_wr_dropped <= w_drop;
            r_frame_done <= w_grant_wr && (r_pend_addr == LAST_ADDR);
            if (w_grant_wr) begin
                r_ram_we     <= 1'b1;
                r_ram_addr   <= r_pend_addr;
                r_ram_wdata  <= r_pend_data;
                r_last_grant <= GRANT_WRITE;
            end else if (w_grant_rd) begin
                r_ram_we     <= 1'b0;
                r_ram_addr   <= bus.rdAddr;
                r_last_grant <= GRANT_READ;
            end else begin
                r_ram_we     <= 1'b0;
            end
        end
    end

    // Camera holding register and frame write-address counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_pend   <= 1'b0;
            r_pend_data <= '0;
            r_pend_addr <= '0;
            r_wr_addr   <= '0;
        end else begin
            if (w_capture) begin
                r_wr_pend   <= 1'b1;
                r_pend_data <= bus.wrData;
                r_pend_addr <= w_cap_addr;
            end else if (w_grant_wr || bus.frameStart) begin
                r_wr_pend   <= 1'b0;
            end
            if (bus.frameStart) begin
                r_wr_addr <= '0;
            end else if (w_grant_wr) begin
                r_wr_addr <= w_addr_next;
            end
        end
    end

    // Read-return pipeline: address out, RAM access, data registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_s1    <= 1'b0;
            r_rd_s2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_s1    <= w_grant_rd;
            r_rd_s2    <= r_rd_s1;
            r_rd_valid <= r_rd_s2;
            if (r_rd_s2) begin
                r_rd_data <= bus.ramRData;
            end
        end
    end

    assign bus.ramAddr   = r_ram_addr;
    assign bus.ramWe     = r_ram_we;
    assign bus.ramWData  = r_ram_wdata;
    assign bus.rdAck     = r_rd_ack;
    assign bus.rdValid   = r_rd_valid;
    assign bus.rdData    = r_rd_data;
    assign bus.wrDropped = r_wr_dropped;
    assign bus.frameDone = r_frame_done;
endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Scoreboard bench for pixel_ram_arbiter with a synchronous RAM model.
module tb_pixel_ram_arbiter;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned ADDR_W       = 17;
    localparam int unsigned FRAME_PIXELS = 76800;
    localparam int unsigned LAST         = FRAME_PIXELS - 1;
    localparam int unsigned MEM_DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pixel_ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pixel_ram_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_PIXELS(FRAME_PIXELS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Frame buffer model: synchronous, read data one cycle after the address
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] ram_q = '0;

    function automatic logic [DATA_W-1:0] pat(input int a);
        return DATA_W'((a * 37) ^ 'h5A3C);
    endfunction

    initial for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = pat(i);

    always @(posedge clk) begin
        if (bus.ramWe) mem[bus.ramAddr] <= bus.ramWData;
        ram_q <= mem[bus.ramAddr];
    end
    assign bus.ramRData = ram_q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int drops_seen  = 0;
    int frames_seen = 0;
    int rdv_seen    = 0;
    int exp_waddr   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_wr [$];
    logic [DATA_W-1:0]        exp_rd [$];
    int                       ack_q  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every RAM write and read return against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ramWe) begin
                if (exp_wr.size() == 0) begin
                    flag_fail("unexpected_write");
                end else begin
                    logic [ADDR_W+DATA_W-1:0] w;
                    w = exp_wr.pop_front();
                    check("ram_write", {bus.ramAddr, bus.ramWData}, w);
                    check("frame_done", bus.frameDone, (int'(w[ADDR_W+DATA_W-1:DATA_W]) == int'(LAST)));
                end
            end else if (bus.frameDone) begin
                flag_fail("frame_done_without_write");
            end
            if (bus.frameDone) frames_seen++;
            if (bus.wrDropped) drops_seen++;
            if (bus.rdAck) ack_q.push_back(cyc);
            if (bus.rdValid) begin
                rdv_seen++;
                if (exp_rd.size() == 0 || ack_q.size() == 0) begin
                    flag_fail("unexpected_rdvalid");
                end else begin
                    int a;
                    logic [DATA_W-1:0] d;
                    a = ack_q.pop_front();
                    d = exp_rd.pop_front();
                    check("rd_data", bus.rdData, d);
                    check("rd_latency", cyc - a, 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [DATA_W-1:0] d);
        exp_wr.push_back({ADDR_W'(exp_waddr), d});
        exp_waddr = (exp_waddr == int'(LAST)) ? 0 : exp_waddr + 1;
    endtask

    // Holds rdReq, moving to the next address on every rdAck
    task automatic do_reads(input int n, input int base);
        int i;
        int guard;
        i = 0;
        guard = 0;
        bus.rdReq  = 1'b1;
        bus.rdAddr = ADDR_W'(base);
        exp_rd.push_back(pat(base));
        while (i < n && guard < 200) begin
            tick();
            guard++;
            if (bus.rdAck) begin
                i++;
                if (i < n) begin
                    bus.rdAddr = ADDR_W'(base + i);
                    exp_rd.push_back(pat(base + i));
                end else begin
                    bus.rdReq = 1'b0;
                end
            end
        end
        bus.rdReq = 1'b0;
        check("read_handshakes", i, n);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ramWe"},     bus.ramWe, 0);
        check({tag, "_ramAddr"},   bus.ramAddr, 0);
        check({tag, "_ramWData"},  bus.ramWData, 0);
        check({tag, "_rdAck"},     bus.rdAck, 0);
        check({tag, "_rdValid"},   bus.rdValid, 0);
        check({tag, "_rdData"},    bus.rdData, 0);
        check({tag, "_wrDropped"}, bus.wrDropped, 0);
        check({tag, "_frameDone"}, bus.frameDone, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int f0;
        int r0;
        reset          = 1'b1;
        bus.frameStart = 1'b0;
        bus.wrValid    = 1'b0;
        bus.wrData     = '0;
        bus.rdReq      = 1'b0;
        bus.rdAddr     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Single write with no reads: on the RAM one cycle after the capture edge
        bus.wrValid = 1'b1;
        bus.wrData  = 16'hF800;
        push_wr(16'hF800);
        tick();
        bus.wrValid = 1'b0;
        tick();
        check("first_write_we",   bus.ramWe, 1);
        check("first_write_addr", bus.ramAddr, 0);
        check("first_write_data", bus.ramWData, 16'hF800);
        tick();
        bus.wrValid = 1'b1;
        bus.wrData  = 16'h001F;
        push_wr(16'h001F);
        tick();
        bus.wrValid = 1'b0;
        repeat (3) tick();

        // Continuous reads with a camera strobe every second cycle
        d0 = drops_seen;
        fork
            do_reads(8, 100000);
            begin
                for (int k = 0; k < 8; k++) begin
                    bus.wrValid = 1'b1;
                    bus.wrData  = DATA_W'(16'h1000 + k);
                    push_wr(DATA_W'(16'h1000 + k));
                    tick();
                    bus.wrValid = 1'b0;
                    tick();
                end
            end
        join
        repeat (4) tick();
        check("no_drop_half_rate", drops_seen - d0, 0);

        // Back-to-back strobes against a read while the last winner was a write
        bus.wrValid = 1'b1;
        bus.wrData  = 16'h2222;
        push_wr(16'h2222);
        tick();
        bus.wrValid = 1'b0;
        repeat (3) tick();
        d0 = drops_seen;
        bus.wrValid = 1'b1;
        bus.wrData  = 16'hAAAA;
        push_wr(16'hAAAA);
        tick();
        fork
            do_reads(2, 100100);
            begin
                bus.wrData = 16'hBBBB;
                tick();
                bus.wrValid = 1'b0;
                check("drop_pulse",       bus.wrDropped, 1);
                check("drop_read_won",    bus.rdAck, 1);
                tick();
                check("held_write_we",    bus.ramWe, 1);
                check("held_write_data",  bus.ramWData, 16'hAAAA);
            end
        join
        repeat (3) tick();
        check("single_drop", drops_seen - d0, 1);

        // Full frame at one pixel per cycle, then one pixel into the next frame
        bus.frameStart = 1'b1;
        tick();
        bus.frameStart = 1'b0;
        exp_waddr = 0;
        f0 = frames_seen;
        d0 = drops_seen;
        bus.wrValid = 1'b1;
        for (int i = 0; i < int'(FRAME_PIXELS) + 1; i++) begin
            bus.wrData = DATA_W'(i);
            push_wr(DATA_W'(i));
            tick();
        end
        bus.wrValid = 1'b0;
        repeat (4) tick();
        check("frame_done_count", frames_seen - f0, 1);
        check("frame_no_drop",    drops_seen - d0, 0);
        check("frame_writes_all", exp_wr.size(), 0);

        // frameStart with a strobe while an old pixel is still pending
        d0 = drops_seen;
        bus.wrValid = 1'b1;
        bus.wrData  = 16'hDEAD;
        tick();
        fork
            do_reads(2, 100200);
            begin
                bus.frameStart = 1'b1;
                bus.wrData     = 16'h07E0;
                exp_waddr      = 0;
                push_wr(16'h07E0);
                tick();
                bus.frameStart = 1'b0;
                bus.wrValid    = 1'b0;
            end
        join
        repeat (4) tick();
        check("frame_start_no_drop", drops_seen - d0, 0);
        check("frame_start_writes",  exp_wr.size(), 0);

        // Reset one cycle after rdAck: in-flight read is lost
        bus.rdReq  = 1'b1;
        bus.rdAddr = ADDR_W'(100300);
        exp_rd.push_back(pat(100300));
        tick();
        check("pre_reset_ack", bus.rdAck, 1);
        bus.rdReq = 1'b0;
        tick();
        reset = 1'b1;
        exp_rd.delete();
        ack_q.delete();
        #1;
        check_outputs_zero("async_reset");
        r0 = rdv_seen;
        repeat (2) tick();
        reset = 1'b0;
        exp_waddr = 0;
        repeat (3) tick();
        check("no_rdvalid_after_reset", rdv_seen - r0, 0);

        // First contention after reset goes to the write
        bus.wrValid = 1'b1;
        bus.wrData  = 16'h1234;
        push_wr(16'h1234);
        tick();
        bus.wrValid = 1'b0;
        bus.rdReq   = 1'b1;
        bus.rdAddr  = ADDR_W'(100301);
        exp_rd.push_back(pat(100301));
        tick();
        check("post_reset_write_wins", bus.ramWe, 1);
        check("post_reset_read_waits", bus.rdAck, 0);
        tick();
        check("post_reset_read_next",  bus.rdAck, 1);
        bus.rdReq = 1'b0;
        repeat (5) tick();
        check("drain_writes", exp_wr.size(), 0);
        check("drain_reads",  exp_rd.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
